// File: rtl/axi_inf_write_burst_splitter_pkg.sv
// Shared AXI constants, FSM state encoding and elaboration helpers for the
// write burst splitter and its length FIFO.
package axi_inf_write_burst_splitter_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam int         BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_AW_VLD = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_inf_len_fifo.sv
// Small synchronous FIFO holding (burst length - 1) for every AW accepted
// whose WLAST has not yet been sent.
module axi_inf_len_fifo
    import axi_inf_write_burst_splitter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             axi_aclk,
    input  logic             axi_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];

    // Pointers wrap explicitly so DEPTH need not fill the pointer range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_inf_write_burst_splitter.sv
// Splits one long AXI4 write request into INCR bursts bounded by MAX_BURST
// and 4 KB pages; issues AW, generates WLAST and tracks B responses.
module axi_inf_write_burst_splitter
    import axi_inf_write_burst_splitter_pkg::*;
#(
    parameter int IDSIZE    = 3,
    parameter int ID        = 0,
    parameter int ASIZE     = 32,
    parameter int DSIZE     = 256,
    parameter int LSIZE     = 8,
    parameter int TLSIZE    = 16,
    parameter int MAX_BURST = 64,
    parameter int MAX_OUT   = 4
) (
    input  logic              axi_aclk,
    input  logic              axi_resetn,
    input  logic              write_req,
    input  logic [ASIZE-1:0]  req_addr,
    input  logic [TLSIZE-1:0] req_len,
    output logic              req_resp,
    output logic              req_done,
    output logic              req_err,
    output logic              pull_data_en,
    output logic [IDSIZE-1:0] axi_awid,
    output logic [ASIZE-1:0]  axi_awaddr,
    output logic [LSIZE-1:0]  axi_awlen,
    output logic [2:0]        axi_awsize,
    output logic [1:0]        axi_awburst,
    output logic              axi_awlock,
    output logic [3:0]        axi_awcache,
    output logic [2:0]        axi_awprot,
    output logic [3:0]        axi_awqos,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic              axi_wlast,
    input  logic              axi_wvalid,
    input  logic              axi_wready,
    output logic              axi_bready,
    input  logic [IDSIZE-1:0] axi_bid,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic [2:0]        dbg_state
);

    localparam int BYTES = DSIZE / 8;
    localparam int LOG_B = clog2(BYTES);
    localparam int OUT_W = clog2(MAX_OUT + 1);

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where valid && ready; the sender holds payload stable while waiting.

    state_t            state;
    state_t            state_nxt;
    logic [ASIZE-1:0]  cur_addr;
    logic [TLSIZE-1:0] rem;
    logic [LSIZE-1:0]  blen_m1;
    logic [LSIZE:0]    blen_full;
    logic [OUT_W-1:0]  out_cnt;
    logic [LSIZE-1:0]  beat_cnt;
    logic              err_acc;
    logic              req_resp_q;
    logic              pull_q;

    logic [31:0]       room;
    logic [31:0]       blen_c;

    logic              accept;
    logic              aw_hs;
    logic              b_hs;
    logic              w_hs;
    logic              fifo_pop;
    logic [LSIZE-1:0]  fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [OUT_W-1:0]  fifo_count;

    assign accept    = (state == ST_IDLE) && write_req;
    assign aw_hs     = (state == ST_AW_VLD) && axi_awready;
    assign b_hs      = axi_bvalid && axi_bready && (axi_bid == IDSIZE'(ID));
    assign w_hs      = axi_wvalid && axi_wready && !fifo_empty;
    assign fifo_pop  = w_hs && axi_wlast;
    assign blen_full = {1'b0, blen_m1} + (LSIZE + 1)'(1);

    // Beats left before the next 4 KB page, capped by burst size and remainder.
    always_comb begin
        room   = '0;
        blen_c = '0;
        room   = (32'(BOUNDARY_4K) - {20'd0, cur_addr[11:0]}) >> LOG_B;
        blen_c = 32'(rem);
        if (blen_c > 32'(MAX_BURST)) begin
            blen_c = 32'(MAX_BURST);
        end
        if (blen_c > room) begin
            blen_c = room;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (write_req) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (rem == '0) begin
                    state_nxt = ST_DRAIN;
                end else if ((out_cnt < OUT_W'(MAX_OUT)) && !fifo_full) begin
                    state_nxt = ST_AW_VLD;
                end
            end
            ST_AW_VLD: begin
                if (axi_awready) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && (out_cnt == '0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            cur_addr   <= '0;
            rem        <= '0;
            blen_m1    <= '0;
            err_acc    <= 1'b0;
            req_resp_q <= 1'b0;
        end else begin
            req_resp_q <= accept;
            if (accept) begin
                cur_addr <= req_addr & ~ASIZE'(BYTES - 1);
                rem      <= req_len;
                err_acc  <= 1'b0;
            end
            if ((state == ST_CALC) && (rem != '0)) begin
                blen_m1 <= LSIZE'(blen_c - 32'd1);
            end
            if (aw_hs) begin
                cur_addr <= cur_addr + (ASIZE'(blen_full) << LOG_B);
                rem      <= rem - TLSIZE'(blen_full);
            end
            if (b_hs && (axi_bresp != RESP_OKAY)) begin
                err_acc <= 1'b1;
            end
        end
    end

    // out_cnt: bursts whose AW was accepted but whose B has not returned.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            out_cnt  <= '0;
            beat_cnt <= '0;
            pull_q   <= 1'b0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   out_cnt <= out_cnt + OUT_W'(1);
                2'b01:   out_cnt <= out_cnt - OUT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
            if (fifo_pop) begin
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + LSIZE'(1);
            end
            // Registered view of next-cycle occupancy so no beat is invited
            // after the final WLAST.
            pull_q <= aw_hs || (fifo_count > OUT_W'(1)) ||
                      ((fifo_count == OUT_W'(1)) && !fifo_pop);
        end
    end

    axi_inf_len_fifo #(
        .WIDTH (LSIZE),
        .DEPTH (MAX_OUT)
    ) u_len_fifo (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .push       (aw_hs),
        .push_data  (blen_m1),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    assign axi_awid     = IDSIZE'(ID);
    assign axi_awaddr   = cur_addr;
    assign axi_awlen    = blen_m1;
    assign axi_awsize   = 3'(LOG_B);
    assign axi_awburst  = BURST_INCR;
    assign axi_awlock   = 1'b0;
    assign axi_awcache  = 4'd0;
    assign axi_awprot   = 3'd0;
    assign axi_awqos    = 4'd0;
    assign axi_awvalid  = (state == ST_AW_VLD);
    assign axi_wlast    = !fifo_empty && (beat_cnt == fifo_head);
    assign axi_bready   = (out_cnt != '0);
    assign req_resp     = req_resp_q;
    assign req_done     = (state == ST_DONE);
    assign req_err      = (state == ST_DONE) && err_acc;
    assign pull_data_en = pull_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_axi_inf_write_burst_splitter.sv
// Self-checking bench: table of requests with expected burst counts, a
// reference burst model feeding AW/W scoreboards, and corner-case sequences.
module tb_axi_inf_write_burst_splitter;

    localparam int IDSIZE    = 3;
    localparam int ID        = 0;
    localparam int ASIZE     = 32;
    localparam int DSIZE     = 256;
    localparam int LSIZE     = 8;
    localparam int TLSIZE    = 16;
    localparam int MAX_BURST = 64;
    localparam int MAX_OUT   = 2;

    logic              axi_aclk = 1'b0;
    logic              axi_resetn = 1'b0;
    logic              write_req;
    logic [ASIZE-1:0]  req_addr;
    logic [TLSIZE-1:0] req_len;
    logic              req_resp, req_done, req_err, pull_data_en;
    logic [IDSIZE-1:0] axi_awid;
    logic [ASIZE-1:0]  axi_awaddr;
    logic [LSIZE-1:0]  axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_awlock;
    logic [3:0]        axi_awcache;
    logic [2:0]        axi_awprot;
    logic [3:0]        axi_awqos;
    logic              axi_awvalid, axi_awready;
    logic              axi_wlast, axi_wvalid, axi_wready;
    logic              axi_bready, axi_bvalid;
    logic [IDSIZE-1:0] axi_bid;
    logic [1:0]        axi_bresp;
    logic [2:0]        dbg_state;

    always #5 axi_aclk = ~axi_aclk;

    axi_inf_write_burst_splitter #(
        .IDSIZE(IDSIZE), .ID(ID), .ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE),
        .TLSIZE(TLSIZE), .MAX_BURST(MAX_BURST), .MAX_OUT(MAX_OUT)
    ) dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn), .write_req(write_req),
        .req_addr(req_addr), .req_len(req_len), .req_resp(req_resp),
        .req_done(req_done), .req_err(req_err), .pull_data_en(pull_data_en),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bready(axi_bready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          exp_bursts;
        logic [7:0]  exp_first_len;
        logic        exp_err;
        int          err_idx;
    } vec_t;

    vec_t        vecs[8];
    logic [39:0] exp_aw_q[$];
    logic [7:0]  exp_w_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          aw_cnt = 0;
    int          wlast_cnt = 0;
    int          w_beat = 0;
    int          b_owed = 0;
    int          b_sent_idx = 0;
    int          err_idx = -1;
    bit          b_auto = 1'b0;
    bit          aw_stall = 1'b0;
    logic [7:0]  first_len = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AW scoreboard: every accepted AW must match the next modelled burst.
    always @(negedge axi_aclk) begin
        if (!axi_resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("aw_hold_valid", 64'(axi_awvalid), 64'(1));
                check("aw_hold_addr", 64'(axi_awaddr), 64'(prev_addr));
                check("aw_hold_len", 64'(axi_awlen), 64'(prev_len));
            end
            if (axi_awvalid && axi_awready) begin
                if (exp_aw_q.size() == 0) begin
                    check("aw_unexpected", 64'(exp_aw_q.size()), 64'(1));
                end else begin
                    logic [39:0] e;
                    e = exp_aw_q.pop_front();
                    check("awaddr", 64'(axi_awaddr), 64'(e[39:8]));
                    check("awlen", 64'(axi_awlen), 64'(e[7:0]));
                    check("aw_fixed", 64'({axi_awid, axi_awsize, axi_awburst, axi_awlock,
                          axi_awcache, axi_awprot, axi_awqos}),
                          64'({3'd0, 3'd5, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
                    exp_w_q.push_back(e[7:0]);
                end
                if (aw_cnt == 0) first_len = axi_awlen;
                aw_cnt++;
            end
            prev_stall = axi_awvalid && !axi_awready;
            prev_addr  = axi_awaddr;
            prev_len   = axi_awlen;
        end
    end

    // W scoreboard: WLAST must fall exactly on the modelled final beat.
    always @(negedge axi_aclk) begin
        if (axi_resetn && axi_wvalid && axi_wready) begin
            if (exp_w_q.size() == 0) begin
                check("w_unexpected", 64'(exp_w_q.size()), 64'(1));
            end else begin
                bit last;
                last = (w_beat == int'(exp_w_q[0]));
                check("wlast", 64'(axi_wlast), 64'(last));
                if (last) begin
                    void'(exp_w_q.pop_front());
                    w_beat = 0;
                    wlast_cnt++;
                    b_owed++;
                end else begin
                    w_beat++;
                end
            end
        end
    end

    initial begin
        axi_awready = 1'b0;
        forever begin
            @(posedge axi_aclk); #1;
            axi_awready = !aw_stall && ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        axi_wvalid = 1'b0;
        axi_wready = 1'b0;
        forever begin
            @(posedge axi_aclk); #1;
            if (!axi_resetn) axi_wvalid = 1'b0;
            else if (!(axi_wvalid && !axi_wready))
                axi_wvalid = pull_data_en && ($urandom_range(0, 3) != 0);
            axi_wready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_b(input logic [2:0] id, input logic [1:0] resp);
        bit hs;
        hs = 1'b0;
        axi_bvalid = 1'b1;
        axi_bid    = id;
        axi_bresp  = resp;
        for (int k = 0; k < 200; k++) begin
            @(negedge axi_aclk);
            if (axi_bready) begin
                hs = 1'b1;
                break;
            end
        end
        check("b_handshake", 64'(hs), 64'(1));
        @(posedge axi_aclk); #1;
        axi_bvalid = 1'b0;
        axi_bid    = '0;
        axi_bresp  = '0;
    endtask

    initial begin
        axi_bvalid = 1'b0;
        axi_bid    = '0;
        axi_bresp  = '0;
        forever begin
            @(posedge axi_aclk); #1;
            if (b_auto && axi_resetn && b_owed > 0) begin
                send_b(3'(ID), (b_sent_idx == err_idx) ? 2'b10 : 2'b00);
                b_owed--;
                b_sent_idx++;
            end
        end
    end

    task automatic start_req(input logic [31:0] addr, input int len, output int nb);
        logic [31:0] a;
        int r, room, b;
        a  = addr & 32'hFFFF_FFE0;
        r  = len;
        nb = 0;
        while (r > 0) begin
            room = (4096 - int'(a[11:0])) >> 5;
            b = r;
            if (b > MAX_BURST) b = MAX_BURST;
            if (b > room) b = room;
            exp_aw_q.push_back({a, 8'(b - 1)});
            a = a + 32'(b * 32);
            r = r - b;
            nb++;
        end
        aw_cnt = 0;
        wlast_cnt = 0;
        b_sent_idx = 0;
        @(posedge axi_aclk); #1;
        write_req = 1'b1;
        req_addr  = addr;
        req_len   = 16'(len);
        @(posedge axi_aclk); #1;
        write_req = 1'b0;
        @(negedge axi_aclk);
        check("req_resp", 64'(req_resp), 64'(1));
    endtask

    task automatic finish_req(input int nb, input logic exp_err, input logic [7:0] exp_first,
                              input bit chk_first);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge axi_aclk);
            if (req_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("req_done_seen", 64'(seen), 64'(1));
        if (seen) begin
            check("req_err", 64'(req_err), 64'(exp_err));
            check("aw_count", 64'(aw_cnt), 64'(nb));
            check("wlast_count", 64'(wlast_cnt), 64'(nb));
            check("aw_left", 64'(exp_aw_q.size()), 64'(0));
            if (chk_first) check("first_awlen", 64'(first_len), 64'(exp_first));
            @(negedge axi_aclk);
            check("req_done_pulse", 64'(req_done), 64'(0));
        end
    endtask

    initial begin
        int nb;
        bit ok;
        write_req = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        axi_resetn = 1'b0;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        check("reset_ctrl", 64'({axi_awvalid, axi_bready, axi_wlast, req_resp, req_done,
              req_err, pull_data_en}), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(0));
        @(posedge axi_aclk); #1;
        axi_resetn = 1'b1;

        vecs[0] = '{32'h0000_0000, 64,  1, 8'd63, 1'b0, -1};
        vecs[1] = '{32'h0000_0000, 200, 4, 8'd63, 1'b0, -1};
        vecs[2] = '{32'h0000_0FC0, 10,  2, 8'd1,  1'b0, -1};
        vecs[3] = '{32'h0000_1F00, 300, 6, 8'd7,  1'b0, -1};
        vecs[4] = '{32'h0000_0013, 1,   1, 8'd0,  1'b0, -1};
        vecs[5] = '{32'hFFFF_FFE0, 3,   2, 8'd0,  1'b0, -1};
        vecs[6] = '{32'h0000_0800, 130, 3, 8'd63, 1'b1, 2};
        vecs[7] = '{32'h0000_0040, 1,   1, 8'd0,  1'b1, 0};

        b_auto = 1'b1;
        for (int i = 0; i < 8; i++) begin
            err_idx = vecs[i].err_idx;
            start_req(vecs[i].addr, vecs[i].len, nb);
            if (i == 1) begin
                // A request while busy must be ignored.
                @(posedge axi_aclk); #1;
                write_req = 1'b1; req_addr = 32'h5000; req_len = 16'd5;
                @(posedge axi_aclk); #1;
                write_req = 1'b0;
                @(negedge axi_aclk);
                check("busy_req_ignored", 64'(req_resp), 64'(0));
            end
            finish_req(vecs[i].exp_bursts, vecs[i].exp_err, vecs[i].exp_first_len, 1'b1);
        end

        err_idx = -1;
        for (int i = 0; i < 4; i++) begin
            start_req(32'($urandom_range(0, 1023)) << 4, int'($urandom_range(1, 150)), nb);
            finish_req(nb, 1'b0, 8'd0, 1'b0);
        end

        // Outstanding limit: two AWs, then stall until one B returns.
        b_auto = 1'b0;
        start_req(32'h0, 256, nb);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge axi_aclk);
            if (b_owed == 2) begin ok = 1'b1; break; end
        end
        check("two_bursts_written", 64'(ok), 64'(1));
        repeat (5) @(negedge axi_aclk);
        check("max_out_aw_count", 64'(aw_cnt), 64'(2));
        check("max_out_awvalid", 64'(axi_awvalid), 64'(0));
        check("max_out_bready", 64'(axi_bready), 64'(1));
        @(posedge axi_aclk); #1;
        send_b(3'(ID), 2'b00);
        b_owed--;
        b_sent_idx++;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge axi_aclk);
            if (aw_cnt == 3) begin ok = 1'b1; break; end
        end
        check("third_aw_after_b", 64'(ok), 64'(1));
        b_auto = 1'b1;
        finish_req(4, 1'b0, 8'd63, 1'b1);

        // Stray B with a foreign ID, then SLVERR on burst 2 of 3.
        b_auto = 1'b0;
        err_idx = 1;
        start_req(32'h2000, 150, nb);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge axi_aclk);
            if (b_owed == 2) begin ok = 1'b1; break; end
        end
        check("err_two_bursts_written", 64'(ok), 64'(1));
        @(posedge axi_aclk); #1;
        send_b(3'(ID + 1), 2'b10);
        repeat (4) @(negedge axi_aclk);
        check("stray_b_aw_count", 64'(aw_cnt), 64'(2));
        check("stray_b_bready", 64'(axi_bready), 64'(1));
        b_auto = 1'b1;
        finish_req(3, 1'b1, 8'd63, 1'b1);
        err_idx = -1;

        // Asynchronous reset while AW is pending.
        aw_stall = 1'b1;
        start_req(32'h100, 256, nb);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge axi_aclk);
            if (axi_awvalid) begin ok = 1'b1; break; end
        end
        check("awvalid_before_reset", 64'(ok), 64'(1));
        #2;
        axi_resetn = 1'b0;
        #1;
        check("rst_ctrl", 64'({axi_awvalid, axi_bready, axi_wlast, req_resp, req_done,
              req_err, pull_data_en}), 64'(0));
        check("rst_awaddr", 64'(axi_awaddr), 64'(0));
        check("rst_awlen", 64'(axi_awlen), 64'(0));
        exp_aw_q.delete();
        exp_w_q.delete();
        b_owed = 0;
        w_beat = 0;
        repeat (3) @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
        aw_stall = 1'b0;
        start_req(32'h40, 0, nb);
        finish_req(0, 1'b0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_inf_write_burst_splitter.md
Name: axi_inf_write_burst_splitter

Overview:
AXI4 write-side control core that takes one long write request (start address and total beat count) and splits it into legal INCR bursts. Each burst is limited by MAX_BURST beats and never crosses a 4 KB boundary. The core drives the AW channel, generates WLAST, tracks B responses with up to MAX_OUT bursts outstanding, and reports completion and error once per request. Data (WDATA/WVALID) comes from an external data mover gated by pull_data_en.

Parameters:
IDSIZE, 3, AXI ID width
ID, 0, AXI ID driven on AWID and matched on BID
ASIZE, 32, address width
DSIZE, 256, data width in bits (power of two, 8..1024); BYTES=DSIZE/8
LSIZE, 8, AWLEN width
TLSIZE, 16, request total-beat-count width
MAX_BURST, 64, max beats per burst (1..2^LSIZE)
MAX_OUT, 4, max bursts with AW accepted but B not yet received (power of two, 1..16)

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
write_req  in  1  request strobe; sampled only in IDLE
req_addr  in  ASIZE  start byte address; must be BYTES-aligned, low bits forced to 0
req_len  in  TLSIZE  total beats
req_resp  out  1  1-cycle pulse: request accepted
req_done  out  1  1-cycle pulse: all bursts complete
req_err  out  1  valid with req_done: any BRESP != OKAY
pull_data_en  out  1  data mover may present W beats
axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  IDSIZE/ASIZE/LSIZE/3/2/1/4/3/4  AW fields
axi_awvalid  out 1;  axi_awready  in 1
axi_wlast  out 1;  axi_wvalid  in 1;  axi_wready  in 1
axi_bready  out 1;  axi_bid  in IDSIZE;  axi_bresp  in 2;  axi_bvalid  in 1

Behaviour:
- Constants: awid=ID, awsize=log2(BYTES), awburst=INCR, awlock/awcache/awprot/awqos=0.
- Reset values: awvalid, bready, wlast, req_resp, req_done, req_err, pull_data_en = 0. All counters and the FIFO are cleared. Reset takes effect immediately, mid-burst included.
- FSM states: IDLE, CALC, AW_VLD, DRAIN, DONE.
- IDLE: on write_req, latch addr and len into cur_addr and rem, clear err_acc, pulse req_resp next cycle, go to CALC. write_req outside IDLE is ignored.
- CALC (1 cycle):
  - If rem==0, go to DRAIN.
  - Otherwise blen = min(rem, MAX_BURST, (4096 - cur_addr[11:0]) >> log2(BYTES)), registered.
  - Go to AW_VLD when out_cnt < MAX_OUT; stay in CALC otherwise.
- AW_VLD: awvalid=1, awaddr=cur_addr, awlen=blen-1, all held stable until awready.
  - On the handshake: cur_addr += blen*BYTES, rem -= blen, push blen-1 into the length FIFO, out_cnt++, return to CALC.
- DRAIN: wait until FIFO empty and out_cnt==0, then go to DONE.
- DONE: req_done=1 and req_err=err_acc for one cycle, then IDLE.
- req_len==0: req_resp, then req_done with req_err=0 about 3 cycles later; no AXI traffic.
- W tracking:
  - beat_cnt counts wvalid&wready handshakes.
  - wlast = FIFO non-empty && beat_cnt == FIFO head.
  - On a handshake with wlast: pop FIFO, beat_cnt=0.
  - pull_data_en = FIFO non-empty (registered). W data never precedes its AW handshake.
- B tracking:
  - bready = (out_cnt != 0).
  - Only a bvalid&bready&(bid==ID) handshake decrements out_cnt; bresp != 2'b00 sets err_acc.
  - AW handshake and B handshake in the same cycle: out_cnt unchanged.
- The FIFO cannot overflow: depth is MAX_OUT and pushes are gated by out_cnt < MAX_OUT.
- Arithmetic: rem is TLSIZE wide, cur_addr is ASIZE wide; both wrap modulo their width, with no error reported.

Decomposition:
- Shared package: AXI constants (BURST_INCR, RESP_OKAY, BOUNDARY_4K), clog2 function, FSM state localparams.
- One sub-module: axi_inf_len_fifo. Synchronous FIFO, width LSIZE, depth MAX_OUT, with push/pop/head/empty/full, same clock and asynchronous active-low reset.

Test Plan:
- DSIZE=256, addr=0x0, len=64, MAX_BURST=64 -> one AW: awlen=63, awsize=5. wlast on the 64th beat only. req_done with req_err=0.
- addr=0x0, len=200 -> AW bursts of awlen 63,63,63,7 at 0x0000, 0x0800, 0x1000, 0x1800. Exactly 4 wlast beats.
- addr=0x0FC0, len=10 -> awlen=1 at 0x0FC0, then awlen=7 at 0x1000. No burst crosses 4 KB.
- MAX_OUT=2, len=256, bvalid withheld -> exactly 2 AW handshakes and awvalid stays low. After one B, the third AW issues.
- bresp=2'b10 on burst 2 of 3, and a stray B with bid!=ID -> stray response ignored, all 3 bursts complete, req_done with req_err=1.
- axi_resetn low mid-burst with awvalid=1 -> all outputs 0 immediately. After release, a len=0 request gives req_resp then req_done with no AW traffic.
